// File: rtl/game_pkg.sv
// Shared constants for the 2048 input path and board engine.
package game_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_UP    = 3'd0;
  localparam logic [CMD_W-1:0] CMD_DOWN  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_RIGHT = 3'd3;
  localparam logic [CMD_W-1:0] CMD_NEW   = 3'd4;

  // Number of direction keys pulsed in one cycle (0..4).
  function automatic logic [2:0] count_dirs(input logic [3:0] dirs);
    return {2'b00, dirs[0]} + {2'b00, dirs[1]} + {2'b00, dirs[2]} + {2'b00, dirs[3]};
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Generic show-ahead FIFO: registered storage, combinational head read.
// flush_load discards everything and leaves push_data as the only entry.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush_load,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      occupancy,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign occupancy = count;
  assign rd_data   = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer, count and storage update; flush overrides push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_load) begin
      mem[0] <= push_data;
      rd_ptr <= '0;
      wr_ptr <= AW'(1);
      count  <= (AW+1)'(1);
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/move_cmd_queue.sv
// Encodes key pulses into move commands, buffers them for the board engine
// and keeps sticky/saturating statistics of commands that had to be dropped.
module move_cmd_queue
  import game_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_new,
  input  logic              clr_status,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd_code,
  output logic [AW:0]       occupancy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [3:0]        dirs;
  logic [2:0]        n_dir;
  logic              sel_valid;
  logic [CMD_W-1:0]  sel_code;
  logic [2:0]        losers;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              full_drop;
  logic [2:0]        drops;
  logic [DROP_W:0]   cnt_base;
  logic [DROP_W:0]   cnt_sum;
  logic [DROP_W-1:0] cnt_next;

  assign dirs  = {key_right, key_left, key_down, key_up};
  assign n_dir = count_dirs(dirs);

  // Pick one command per cycle; every other direction pulse is a loser.
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = CMD_UP;
    losers    = 3'd0;
    if (key_new) begin
      sel_valid = 1'b1;
      sel_code  = CMD_NEW;
      losers    = n_dir;
    end else if (n_dir != 3'd0) begin
      sel_valid = 1'b1;
      losers    = n_dir - 3'd1;
      if (key_up)        sel_code = CMD_UP;
      else if (key_down) sel_code = CMD_DOWN;
      else if (key_left) sel_code = CMD_LEFT;
      else               sel_code = CMD_RIGHT;
    end
  end

  // New-game goes through flush_load, never through the normal push path,
  // so it can never be lost to a full queue.
  assign fifo_pop  = cmd_valid && cmd_ready;
  assign fifo_push = sel_valid && !key_new;
  assign full_drop = fifo_push && fifo_full && !fifo_pop;
  assign drops     = losers + {2'b00, full_drop};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (sel_code),
    .pop        (fifo_pop),
    .flush_load (key_new),
    .rd_data    (cmd_code),
    .occupancy  (occupancy),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign cmd_valid = !fifo_empty;

  // clr_status restarts the count from this cycle's drops rather than from zero.
  always_comb begin
    cnt_base = clr_status ? '0 : {1'b0, drop_cnt};
    cnt_sum  = cnt_base + (DROP_W+1)'(drops);
    cnt_next = cnt_sum[DROP_W] ? '1 : cnt_sum[DROP_W-1:0];
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= (clr_status ? 1'b0 : overflow) | (drops != 3'd0);
      drop_cnt <= cnt_next;
    end
  end

endmodule
